// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared state, opcode, alu_phase and instruction-class definitions for mc_ctrl
package mc_pkg;

  // State encodings (also visible on the debug state port)
  localparam logic [2:0] ST_IF   = 3'd0;
  localparam logic [2:0] ST_ID   = 3'd1;
  localparam logic [2:0] ST_EX   = 3'd2;
  localparam logic [2:0] ST_MEM  = 3'd3;
  localparam logic [2:0] ST_WB   = 3'd4;
  localparam logic [2:0] ST_HALT = 3'd7;

  typedef enum logic [2:0] {
    S_IF   = ST_IF,
    S_ID   = ST_ID,
    S_EX   = ST_EX,
    S_MEM  = ST_MEM,
    S_WB   = ST_WB,
    S_HALT = ST_HALT
  } state_e;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LHU   = 6'b100101;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LBU   = 6'b100100;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_SH    = 6'b101001;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  // I-type ALU ops occupy 001000..001111
  localparam logic [2:0] OP_IALU_HI = 3'b001;

  // Funct codes (instr[5:0])
  localparam logic [5:0] FN_JR = 6'b001000;

  // ALU operand phase
  localparam logic [1:0] AP_PC4 = 2'b00;
  localparam logic [1:0] AP_BR  = 2'b01;
  localparam logic [1:0] AP_EXE = 2'b10;

  typedef enum logic [3:0] {
    IC_R,
    IC_LOAD,
    IC_STORE,
    IC_BRANCH,
    IC_JUMP,
    IC_JAL,
    IC_JR,
    IC_IALU,
    IC_ILL
  } iclass_e;

endpackage

// File: rtl/mc_iclass.sv
// rtl/mc_iclass.sv - combinational Op/Funct to instruction-class decode
module mc_iclass
  import mc_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  output iclass_e    cls_o
);

  // Anything not matched below is an illegal opcode
  always_comb begin
    cls_o = IC_ILL;
    case (op_i)
      OP_RTYPE:                         cls_o = (funct_i == FN_JR) ? IC_JR : IC_R;
      OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU: cls_o = IC_LOAD;
      OP_SW, OP_SH, OP_SB:              cls_o = IC_STORE;
      OP_BEQ, OP_BNE:                   cls_o = IC_BRANCH;
      OP_J:                             cls_o = IC_JUMP;
      OP_JAL:                           cls_o = IC_JAL;
      default: begin
        if (op_i[5:3] == OP_IALU_HI) cls_o = IC_IALU;
      end
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multicycle MIPS sequencing controller; MC_CTRL_PERF_EN adds cyc_cnt/ret_cnt
module mc_ctrl
  import mc_pkg::*;
#(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       Op,
  input  logic [5:0]       Funct,
  input  logic             Zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_cond,
  output logic             reg_we,
  output logic [1:0]       alu_phase,
  output logic [2:0]       state,
  output logic             retire,
  output logic             illegal,
  output logic             bus_err
`ifdef MC_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] ret_cnt
`endif
);

  // Last wait count that may still be followed by a successful mem_ready
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

  state_e     state_q;
  logic [7:0] wait_q;
  iclass_e    cls_q;
  logic       bne_q;
  logic       illegal_q;
  logic       bus_err_q;
  iclass_e    cls_id;
  logic       wait_expire;

  mc_iclass u_iclass (
    .op_i    (Op),
    .funct_i (Funct),
    .cls_o   (cls_id)
  );

  // This cycle is the WAIT_MAX-th consecutive one without mem_ready
  assign wait_expire = !mem_ready && (wait_q == WAIT_LAST);

  // Sequencer: state, wait counter, latched class and sticky flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IF;
      wait_q    <= 8'd0;
      cls_q     <= IC_ILL;
      bne_q     <= 1'b0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      case (state_q)
        S_IF: begin
          if (mem_ready) begin
            wait_q  <= 8'd0;
            state_q <= S_ID;
          end else if (wait_expire) begin
            bus_err_q <= 1'b1;
            state_q   <= S_HALT;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        S_ID: begin
          // Class is held so EX/MEM do not depend on Op after ID
          cls_q <= cls_id;
          bne_q <= Op[0];
          case (cls_id)
            IC_JUMP, IC_JAL, IC_JR: state_q <= S_IF;
            IC_ILL: begin
              illegal_q <= 1'b1;
              state_q   <= S_HALT;
            end
            default: state_q <= S_EX;
          endcase
        end
        S_EX: begin
          case (cls_q)
            IC_BRANCH:         state_q <= S_IF;
            IC_LOAD, IC_STORE: state_q <= S_MEM;
            default:           state_q <= S_WB;
          endcase
        end
        S_MEM: begin
          if (mem_ready) begin
            wait_q  <= 8'd0;
            state_q <= (cls_q == IC_STORE) ? S_IF : S_WB;
          end else if (wait_expire) begin
            bus_err_q <= 1'b1;
            state_q   <= S_HALT;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        S_WB:    state_q <= S_IF;
        default: state_q <= S_HALT;
      endcase
    end
  end

  // Strobes depend on the handshake/decode of the current cycle; reset forces them low at once
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    iord      = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_cond   = 1'b0;
    reg_we    = 1'b0;
    alu_phase = AP_PC4;
    retire    = 1'b0;
    if (rst) begin
      case (state_q)
        S_IF: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_we = 1'b1;
            pc_we = 1'b1;
          end
        end
        S_ID: begin
          case (cls_id)
            IC_JUMP, IC_JR: begin
              pc_we  = 1'b1;
              retire = 1'b1;
            end
            IC_JAL: begin
              pc_we  = 1'b1;
              reg_we = 1'b1;
              retire = 1'b1;
            end
            default: ;
          endcase
        end
        S_EX: begin
          alu_phase = AP_EXE;
          if (cls_q == IC_BRANCH) begin
            alu_phase = AP_BR;
            pc_cond   = 1'b1;
            pc_we     = bne_q ? !Zero : Zero;
            retire    = 1'b1;
          end
        end
        S_MEM: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          mem_we  = (cls_q == IC_STORE);
          if (mem_ready && (cls_q == IC_STORE)) retire = 1'b1;
        end
        S_WB: begin
          reg_we = 1'b1;
          retire = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign state   = state_q;
  assign illegal = illegal_q;
  assign bus_err = bus_err_q;

`ifdef MC_CTRL_PERF_EN
  logic [CNT_W-1:0] cyc_q;
  logic [CNT_W-1:0] ret_q;

  // Free-running active-cycle and retired-instruction counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else begin
      if (state_q != S_HALT) cyc_q <= cyc_q + {{(CNT_W-1){1'b0}}, 1'b1};
      if (retire)            ret_q <= ret_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign cyc_cnt = cyc_q;
  assign ret_cnt = ret_q;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - self-checking bench for mc_ctrl (counter checks when MC_CTRL_PERF_EN is defined)
`timescale 1ns/1ps
module tb_mc_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] Op, Funct;
  logic       Zero, mem_ready;
  logic       mem_req, mem_we, iord, ir_we, pc_we, pc_cond, reg_we;
  logic [1:0] alu_phase;
  logic [2:0] state;
  logic       retire, illegal, bus_err;
`ifdef MC_CTRL_PERF_EN
  logic [31:0] cyc_cnt, ret_cnt;
`endif

  always #5 clk = ~clk;

  mc_ctrl #(.WAIT_MAX(15), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_we(ir_we), .pc_we(pc_we),
    .pc_cond(pc_cond), .reg_we(reg_we), .alu_phase(alu_phase), .state(state),
    .retire(retire), .illegal(illegal), .bus_err(bus_err)
`ifdef MC_CTRL_PERF_EN
    , .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt)
`endif
  );

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    int if_w;
    int mem_w;
    int cyc;
    int reg_n;
    int reg_st;
    int pc_n;
    int cond_n;
    int memw_n;
  } vec_t;

  vec_t vecs[16];
  vec_t sb_q[$];
  int   seq[$];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic int all_outs();
    return int'({mem_req, mem_we, iord, ir_we, pc_we, pc_cond, reg_we,
                 alu_phase, state, retire, illegal, bus_err});
  endfunction

  // Called at posedge+1; leaves time at posedge+1 with the DUT back in IF
  task automatic run_vec(input int idx, input vec_t v);
    int if_c = 0, mem_c = 0, cyc = 0, reg_n = 0, reg_st = 0, pc_n = 0;
    int cond_n = 0, ir_n = 0, memw_n = 0, viol = 0;
    bit done = 0;
    bit is_st, is_br, is_jal;
    vec_t e;
    is_st  = (v.op[5:3] == 3'b101);
    is_br  = (v.op[5:1] == 5'b00010);
    is_jal = (v.op == 6'b000011);
    Op = v.op; Funct = v.fn; Zero = v.z;
    sb_q.push_back(v);
    seq.delete();
    for (int c = 0; c < 80 && !done; c++) begin
      case (state)
        3'd0: begin mem_ready = (if_c >= v.if_w); if_c++; end
        3'd3: begin mem_ready = (mem_c >= v.mem_w); mem_c++; end
        default: mem_ready = 1'($urandom_range(0, 1));
      endcase
      #4;
      cyc++;
      seq.push_back(int'(state));
      if (reg_we) begin reg_n++; reg_st = int'(state); end
      if (pc_we) pc_n++;
      if (pc_cond) cond_n++;
      if (ir_we) ir_n++;
      if (mem_req && mem_we && mem_ready) memw_n++;
      if (state inside {3'd5, 3'd6}) viol++;
      if (reg_we && !(state == 3'd4 || (state == 3'd1 && is_jal))) viol++;
      if (ir_we && !(state == 3'd0 && mem_ready)) viol++;
      if (mem_req != (state == 3'd0 || state == 3'd3)) viol++;
      if (state == 3'd0 && (iord || mem_we || alu_phase != 2'b00)) viol++;
      if (state == 3'd3 && (!iord || mem_we != is_st)) viol++;
      if (state == 3'd2 && alu_phase != (is_br ? 2'b01 : 2'b10)) viol++;
      if (pc_cond && state != 3'd2) viol++;
      if (illegal || bus_err) viol++;
      if (retire) done = 1;
      @(posedge clk); #1;
    end
    e = sb_q.pop_front();
    chk($sformatf("vec%0d retired", idx), int'(done), 1);
    chk($sformatf("vec%0d cycles", idx), cyc, e.cyc);
    chk($sformatf("vec%0d reg_we count", idx), reg_n, e.reg_n);
    chk($sformatf("vec%0d reg_we state", idx), reg_st, e.reg_st);
    chk($sformatf("vec%0d pc_we count", idx), pc_n, e.pc_n);
    chk($sformatf("vec%0d pc_cond count", idx), cond_n, e.cond_n);
    chk($sformatf("vec%0d ir_we count", idx), ir_n, 1);
    chk($sformatf("vec%0d store writes", idx), memw_n, e.memw_n);
    chk($sformatf("vec%0d invariant violations", idx), viol, 0);
  endtask

  // Called at posedge+1: one-cycle reset pulse, returns at posedge+1 in IF
  task automatic do_reset(input string nm);
    rst = 1'b0; mem_ready = 1'b1;
    #1;
    chk({nm, " outputs in reset"}, all_outs(), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    chk({nm, " state after reset"}, int'(state), 0);
    chk({nm, " flags after reset"}, int'({illegal, bus_err}), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int memc, memw, en, mis;
    bit halted;
    int lw_seq[9] = '{0, 0, 0, 1, 2, 3, 3, 3, 4};

    //           op         fn         z  ifw memw cyc reg st pc cond memw
    vecs[0]  = '{6'b100011, 6'b000000, 0, 2,  2,   9,  1, 4, 1, 0, 0};  // lw, waits
    vecs[1]  = '{6'b000100, 6'b000000, 1, 0,  0,   3,  0, 0, 2, 1, 0};  // beq taken
    vecs[2]  = '{6'b000101, 6'b000000, 1, 0,  0,   3,  0, 0, 1, 1, 0};  // bne not taken
    vecs[3]  = '{6'b000011, 6'b000000, 0, 0,  0,   2,  1, 1, 2, 0, 0};  // jal
    vecs[4]  = '{6'b000010, 6'b000000, 0, 0,  0,   2,  0, 0, 2, 0, 0};  // j
    vecs[5]  = '{6'b000000, 6'b001000, 0, 0,  0,   2,  0, 0, 2, 0, 0};  // jr
    vecs[6]  = '{6'b000000, 6'b100000, 0, 0,  0,   4,  1, 4, 1, 0, 0};  // add
    vecs[7]  = '{6'b001101, 6'b000000, 0, 0,  0,   4,  1, 4, 1, 0, 0};  // ori
    vecs[8]  = '{6'b101011, 6'b000000, 0, 0,  0,   4,  0, 0, 1, 0, 1};  // sw
    vecs[9]  = '{6'b101000, 6'b000000, 0, 1,  3,   8,  0, 0, 1, 0, 1};  // sb, waits
    vecs[10] = '{6'b100100, 6'b000000, 0, 0,  0,   5,  1, 4, 1, 0, 0};  // lbu
    vecs[11] = '{6'b101001, 6'b000000, 0, 0,  14,  18, 0, 0, 1, 0, 1};  // sh, ready at limit
    vecs[12] = '{6'b000101, 6'b000000, 0, 14, 0,   17, 0, 0, 2, 1, 0};  // bne taken, fetch at limit
    vecs[13] = '{6'b000100, 6'b000000, 0, 0,  0,   3,  0, 0, 1, 1, 0};  // beq not taken
    vecs[14] = '{6'b100001, 6'b000000, 0, 3,  0,   8,  1, 4, 1, 0, 0};  // lh, fetch waits
    vecs[15] = '{6'b001010, 6'b000000, 1, 0,  0,   4,  1, 4, 1, 0, 0};  // slti

    rst = 1'b0; mem_ready = 1'b1; Op = 6'b0; Funct = 6'b0; Zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("initial reset outputs", all_outs(), 0);
    @(posedge clk); #1;
    rst = 1'b1;

    for (int i = 0; i < 16; i++) begin
      run_vec(i, vecs[i]);
      if (i == 0) begin
        mis = 0;
        for (int k = 0; k < 9 && k < seq.size(); k++) if (seq[k] != lw_seq[k]) mis++;
        chk("lw state sequence length", seq.size(), 9);
        chk("lw state sequence mismatches", mis, 0);
      end
    end

    // Store that never sees mem_ready: timeout into HALT
    Op = 6'b101011; Funct = 6'b0; Zero = 1'b0;
    memc = 0; memw = 0; halted = 0;
    for (int c = 0; c < 40 && !halted; c++) begin
      if (state == 3'd7) halted = 1;
      else begin
        mem_ready = (state == 3'd0);
        #4;
        if (state == 3'd3) memc++;
        if (mem_req && mem_we && mem_ready) memw++;
        @(posedge clk); #1;
      end
    end
    chk("timeout reached HALT", int'(halted), 1);
    chk("timeout MEM cycles", memc, 15);
    chk("timeout store writes", memw, 0);
    chk("timeout bus_err", int'(bus_err), 1);
    chk("timeout mem_req", int'(mem_req), 0);
    chk("timeout illegal", int'(illegal), 0);
    en = 0;
    for (int c = 0; c < 10; c++) begin
      mem_ready = 1'($urandom_range(0, 1));
      #4;
      if (mem_req | mem_we | ir_we | pc_we | reg_we | retire | pc_cond) en++;
      @(posedge clk); #1;
    end
    chk("HALT enables", en, 0);
    chk("HALT state held", int'(state), 7);
    chk("HALT bus_err held", int'(bus_err), 1);
    do_reset("after timeout");

    // Illegal opcode
    Op = 6'b111111; mem_ready = 1'b1;
    @(posedge clk); #1;
    chk("illegal in ID", int'(state), 1);
    mem_ready = 1'b0;
    @(posedge clk); #1;
    chk("illegal state", int'(state), 7);
    chk("illegal flag", int'(illegal), 1);
    chk("illegal bus_err", int'(bus_err), 0);
    do_reset("after illegal");

    // Reset in the middle of a fetch request
    mem_ready = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    chk("req before mid reset", int'(mem_req), 1);
    rst = 1'b0;
    #1;
    chk("req during mid reset", int'(mem_req), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    // Wait counter must have restarted: a fetch at the limit still succeeds
    run_vec(100, '{6'b101011, 6'b000000, 0, 14, 0, 18, 0, 0, 1, 0, 1});

`ifdef MC_CTRL_PERF_EN
    do_reset("perf");
    run_vec(200, vecs[6]);
    run_vec(201, vecs[7]);
    run_vec(202, vecs[6]);
    run_vec(203, vecs[15]);
    chk("perf ret_cnt", int'(ret_cnt), 4);
    chk("perf cyc_cnt", int'(cyc_cnt), 16);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
Multicycle sequencing controller for the MIPS datapath: PC, register file, ALU, EXT and a single shared instruction/data memory port. It steps each instruction through IF/ID/EX/MEM/WB phases and gates every architectural write enable. It waits on a memory ready handshake and flags illegal opcodes and memory timeouts. The combinational ctrl decoder still supplies ALUOp, EXTOp, LD/SV and the mux selects; this block decides only *when* those take effect.

Parameters:
WAIT_MAX, 15, maximum cycles to wait for mem_ready before raising bus_err (1..255)
CNT_W, 32, width of the optional performance counters

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
Op  in  6  instr[31:26]; sampled only in ID, from the latched IR
Funct  in  6  instr[5:0]
Zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the current request this cycle
mem_req  out  1  memory request, held until the mem_ready cycle
mem_we  out  1  store request; valid only while mem_req=1
iord  out  1  memory address select: 0=PC (fetch), 1=aluout (data)
ir_we  out  1  latch the instruction register
pc_we  out  1  write NPC into PC
pc_cond  out  1  PC write is qualified by the branch result (EX of beq/bne)
reg_we  out  1  register file write
alu_phase  out  2  00=PC+4, 01=branch target, 10=execute operands
state  out  3  current state, for debug
retire  out  1  one-cycle pulse when an instruction completes
illegal  out  1  sticky illegal-opcode flag
bus_err  out  1  sticky memory-timeout flag

Behaviour:
- Reset (rst=0, asynchronous):
  - state goes to IF and the wait counter to 0.
  - All outputs are 0, including illegal and bus_err; the perf counters are 0.
  - If reset is asserted mid-request, mem_req drops immediately and no write completes.
- State encoding: IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=7.
- IF:
  - mem_req=1, iord=0, alu_phase=00.
  - On mem_ready: ir_we=1 and pc_we=1 in the same cycle, then go to ID.
  - Otherwise stay in IF.
- ID:
  - Classify Op/Funct.
  - j: pc_we=1, retire=1, go to IF.
  - jal: pc_we=1, reg_we=1 (WDSel selects PC+4 into $31), retire=1, go to IF.
  - jr (Op=0, Funct=001000): pc_we=1, retire=1, go to IF.
  - Unknown opcode: illegal=1, go to HALT.
  - Everything else goes to EX.
- Legal opcodes:
  - R-type (Op=000000).
  - Loads: lw 100011, lh 100001, lhu 100101, lb 100000, lbu 100100.
  - Stores: sw 101011, sh 101001, sb 101000.
  - Branches: beq 000100, bne 000101.
  - Jumps: j 000010, jal 000011.
  - I-type ALU: 001000–001111.
- EX:
  - alu_phase=10.
  - beq/bne: alu_phase=01, pc_cond=1, pc_we = (beq ? Zero : ~Zero), retire=1, go to IF.
  - Load/store: go to MEM.
  - R-type and I-type ALU: go to WB.
- MEM:
  - mem_req=1, iord=1, mem_we = store.
  - On mem_ready: a store gives retire=1 and goes to IF; a load goes to WB.
  - A store's write occurs only in the mem_ready cycle.
- WB:
  - reg_we=1 for exactly one cycle, retire=1, go to IF.
- Wait counter:
  - Counts the consecutive cycles in IF or MEM without mem_ready, and clears on mem_ready.
  - When it reaches WAIT_MAX with mem_ready still 0: bus_err=1, mem_req drops, go to HALT.
  - mem_ready in the same cycle as the limit counts as success.
- HALT: all enables are 0 and the flags stay set. Only reset exits HALT.
- Invariants:
  - No write enable is ever high outside its stated state.
  - mem_req, iord and mem_we are stable for the whole request.
- Latency in cycles, with zero memory wait:
  - j/jal/jr: 2.
  - Branch: 3.
  - Store and ALU ops: 4.
  - Load: 5.
  - Each wait cycle adds 1.

Optional Feature:
MC_CTRL_PERF_EN:
- When defined, adds output ports cyc_cnt[CNT_W-1:0] and ret_cnt[CNT_W-1:0].
- cyc_cnt increments every cycle outside HALT; ret_cnt increments on retire.
- Both wrap modulo 2^CNT_W and clear on reset.
- When not defined, neither port nor counter exists.

Decomposition:
- Package mc_pkg holds:
  - The state localparams.
  - The opcode/funct constants.
  - The alu_phase encodings.
  - An instruction-class enumeration: R, LOAD, STORE, BRANCH, JUMP, JAL, JR, IALU, ILL.
- One sub-module, mc_iclass: purely combinational Op/Funct to class decode, reused by the ctrl decoder.

Test Plan:
- lw with mem_ready delayed 2 cycles in both IF and MEM -> state sequence IF,IF,IF,ID,EX,MEM,MEM,MEM,WB; reg_we only in WB; one retire; 9 cycles total.
- beq with Zero=1, then bne with Zero=1 -> first gives pc_we=1 with pc_cond=1 in EX; second gives pc_we=0; both retire after 3 cycles.
- jal with zero wait -> in ID, pc_we=1 and reg_we=1 in the same cycle; retire; back in IF on the next cycle.
- sw with mem_ready held 0 for 15 cycles (WAIT_MAX=15) -> bus_err=1, state=7, mem_req=0, no mem_we pulse with ready; still halted 10 cycles later.
- Op=111111 -> illegal=1 and HALT after ID; rst low for 1 cycle -> all outputs 0, state=IF, flags cleared.
- With MC_CTRL_PERF_EN: run 4 ALU instructions with zero wait -> ret_cnt=4, cyc_cnt=16.
